tape_transport: RTL and testbench

//  Cassette transport model that generates the tape position/length pair consumed by the

---
 rtl/tape_transport.sv | 162 ++++++++++++++++
 tb/tb_tape_transport.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tape_transport.sv
// Cassette transport model: play/stop/fast-forward/rewind FSM that produces the
// tape position/length pair and enable for the progress-bar overlay.
module tape_transport #(
   parameter int unsigned TICK_DIV = 6667,
   parameter int unsigned FF_MULT  = 8,
   parameter int unsigned POS_W    = 24
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             cmd_play,
   input  logic             cmd_stop,
   input  logic             cmd_ff,
   input  logic             cmd_rew,
   input  logic             loop_en,
   input  logic [POS_W-1:0] tape_len,
   output logic [POS_W-1:0] pos,
   output logic [POS_W-1:0] max,
   output logic [2:0]       state,
   output logic             motor,
   output logic             at_end,
   output logic             ena
);

   localparam int unsigned     PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [POS_W:0]  STEP      = (POS_W + 1)'(FF_MULT);
   localparam logic [POS_W:0]  ONE       = (POS_W + 1)'(1);

   typedef enum logic [2:0] {
      ST_STOP = 3'd0,
      ST_PLAY = 3'd1,
      ST_FF   = 3'd2,
      ST_REW  = 3'd3,
      ST_END  = 3'd4
   } state_e;

   state_e            state_q, state_d, st_t;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [POS_W-1:0]  max_q, max_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic              motor_q, at_end_q, ena_q;
   logic              moving, tick, tick_trans;
   logic [POS_W:0]    inc_w, add_w, sub_w;

   always_comb begin
      state_d    = state_q;
      st_t       = state_q;
      pos_d      = pos_q;
      max_d      = max_q;
      presc_d    = '0;
      tick       = 1'b0;
      tick_trans = 1'b0;
      inc_w      = {1'b0, pos_q} + ONE;
      add_w      = {1'b0, pos_q} + STEP;
      sub_w      = {1'b0, pos_q} - STEP;
      moving     = (state_q == ST_PLAY) || (state_q == ST_FF) || (state_q == ST_REW);

      if (moving) begin
         tick    = (presc_q == TICK_LAST);
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      // Tick-driven position update first; st_t is the state the tick leaves us in.
      case (state_q)
         ST_STOP: begin
            max_d = tape_len;
            if (tape_len < pos_q) pos_d = tape_len;
         end
         ST_PLAY: begin
            if (tick) begin
               if (inc_w >= {1'b0, max_q}) begin
                  if (loop_en) begin
                     pos_d = '0;
                  end else begin
                     pos_d      = max_q;
                     st_t       = ST_END;
                     tick_trans = 1'b1;
                  end
               end else begin
                  pos_d = inc_w[POS_W-1:0];
               end
            end
         end
         ST_FF: begin
            if (tick) begin
               if (add_w >= {1'b0, max_q}) begin
                  pos_d      = max_q;
                  st_t       = ST_END;
                  tick_trans = 1'b1;
               end else begin
                  pos_d = add_w[POS_W-1:0];
               end
            end
         end
         ST_REW: begin
            if (tick) begin
               if (sub_w[POS_W] || (sub_w == '0)) begin
                  pos_d      = '0;
                  st_t       = ST_STOP;
                  tick_trans = 1'b1;
               end else begin
                  pos_d = sub_w[POS_W-1:0];
               end
            end
         end
         default: ;
      endcase

      state_d = st_t;
      if (cmd_stop) begin
         state_d = ST_STOP;
      end else if (cmd_rew) begin
         case (st_t)
            ST_STOP:                   if (pos_d != '0) state_d = ST_REW;
            ST_PLAY, ST_FF, ST_END:    state_d = ST_REW;
            default: ;
         endcase
      end else if (cmd_ff && !tick_trans) begin
         case (st_t)
            ST_STOP:          if ((max_d != '0) && (pos_d != max_d)) state_d = ST_FF;
            ST_PLAY, ST_REW:  state_d = ST_FF;
            default: ;
         endcase
      end else if (cmd_play && !tick_trans) begin
         case (st_t)
            ST_STOP:          if ((max_d != '0) && (pos_d != max_d)) state_d = ST_PLAY;
            ST_FF, ST_REW:    state_d = ST_PLAY;
            default: ;
         endcase
      end

      if (state_d != state_q) presc_d = '0;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_STOP;
         pos_q    <= '0;
         max_q    <= '0;
         presc_q  <= '0;
         motor_q  <= 1'b0;
         at_end_q <= 1'b0;
         ena_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         max_q    <= max_d;
         presc_q  <= presc_d;
         motor_q  <= (state_d == ST_PLAY) || (state_d == ST_FF) || (state_d == ST_REW);
         at_end_q <= (state_d == ST_END);
         ena_q    <= (max_d != '0);
      end
   end

   assign pos    = pos_q;
   assign max    = max_q;
   assign state  = state_q;
   assign motor  = motor_q;
   assign at_end = at_end_q;
   assign ena    = ena_q;

endmodule

// File: tb/tb_tape_transport.sv
// Vector-table bench for tape_transport (TICK_DIV=4, FF_MULT=8, 8-bit positions)
// with a queue scoreboard of expected outputs.
module tb_tape_transport;

   localparam logic [3:0] C_NONE = 4'b0000;
   localparam logic [3:0] C_PLAY = 4'b0001;
   localparam logic [3:0] C_FF   = 4'b0010;
   localparam logic [3:0] C_REW  = 4'b0100;
   localparam logic [3:0] C_STOP = 4'b1000;

   typedef struct {
      string       name;
      logic [3:0]  cmd;
      logic        loop;
      logic [7:0]  len;
      int unsigned wait_n;
      logic [7:0]  pos;
      logic [7:0]  mx;
      logic [2:0]  st;
      logic        m;
      logic        e;
      logic        en;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] pos;
      logic [7:0] mx;
      logic [2:0] st;
      logic       m;
      logic       e;
      logic       en;
   } exp_t;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_play = 1'b0, cmd_stop = 1'b0, cmd_ff = 1'b0, cmd_rew = 1'b0;
   logic       loop_en = 1'b0;
   logic [7:0] tape_len = 8'd20;
   logic [7:0] pos, max;
   logic [2:0] state;
   logic       motor, at_end, ena;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   vec_t        tbl[$];
   exp_t        sb[$];

   tape_transport #(.TICK_DIV(4), .FF_MULT(8), .POS_W(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cmd_play(cmd_play), .cmd_stop(cmd_stop), .cmd_ff(cmd_ff), .cmd_rew(cmd_rew),
      .loop_en(loop_en), .tape_len(tape_len),
      .pos(pos), .max(max), .state(state),
      .motor(motor), .at_end(at_end), .ena(ena)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic vec_t mk(string name, logic [3:0] cmd, logic loop, logic [7:0] len,
                               int unsigned w, logic [7:0] p, logic [7:0] mx, logic [2:0] st,
                               logic m, logic e, logic en);
      vec_t v;
      v.name = name; v.cmd = cmd; v.loop = loop; v.len = len; v.wait_n = w;
      v.pos = p; v.mx = mx; v.st = st; v.m = m; v.e = e; v.en = en;
      return v;
   endfunction

   task automatic expect_now(string name, logic [7:0] p, logic [7:0] mx, logic [2:0] st,
                             logic m, logic e, logic en);
      exp_t x;
      x.name = name; x.pos = p; x.mx = mx; x.st = st; x.m = m; x.e = e; x.en = en;
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t x;
      n_vec++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard: no expected entry, got pos=%0d state=%0d", pos, state);
      end else begin
         x = sb.pop_front();
         if (pos !== x.pos || max !== x.mx || state !== x.st ||
             motor !== x.m || at_end !== x.e || ena !== x.en) begin
            n_bad++;
            $display("FAIL %s: got pos=%0d max=%0d state=%0d motor=%0b at_end=%0b ena=%0b, expected pos=%0d max=%0d state=%0d motor=%0b at_end=%0b ena=%0b",
                     x.name, pos, max, state, motor, at_end, ena,
                     x.pos, x.mx, x.st, x.m, x.e, x.en);
         end
      end
   endtask

   // Called at a falling edge: command held across exactly one rising edge, then wait_n more.
   task automatic run_vec(vec_t v);
      cmd_stop = v.cmd[3]; cmd_rew = v.cmd[2]; cmd_ff = v.cmd[1]; cmd_play = v.cmd[0];
      loop_en  = v.loop;
      tape_len = v.len;
      expect_now(v.name, v.pos, v.mx, v.st, v.m, v.e, v.en);
      @(negedge clk_sys);
      cmd_stop = 1'b0; cmd_rew = 1'b0; cmd_ff = 1'b0; cmd_play = 1'b0;
      repeat (v.wait_n) @(negedge clk_sys);
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          name            cmd            lp   len  w   pos mx  st m  e  en
      tbl.push_back(mk("idle2",    C_NONE,        0, 20,  1,  0, 20, 0, 0, 0, 1));
      tbl.push_back(mk("play1",    C_PLAY,        0, 20,  4,  1, 20, 1, 1, 0, 1));
      tbl.push_back(mk("play3",    C_NONE,        0, 20,  7,  3, 20, 1, 1, 0, 1));
      tbl.push_back(mk("play_end", C_NONE,        0, 20, 67, 20, 20, 4, 0, 1, 1));
      tbl.push_back(mk("end_play", C_PLAY,        0, 20,  3, 20, 20, 4, 0, 1, 1));
      tbl.push_back(mk("end_ff",   C_FF,          0, 20,  3, 20, 20, 4, 0, 1, 1));
      tbl.push_back(mk("end_rew",  C_REW,         0, 20,  0, 20, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rew12",    C_NONE,        0, 20,  3, 12, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rew_stop", C_STOP,        0, 20,  0, 12, 20, 0, 0, 0, 1));
      tbl.push_back(mk("play_stp", C_PLAY|C_STOP, 0, 20,  2, 12, 20, 0, 0, 0, 1));
      tbl.push_back(mk("play12",   C_PLAY,        0, 20,  0, 12, 20, 1, 1, 0, 1));
      tbl.push_back(mk("ff_play",  C_FF|C_PLAY,   0, 20,  0, 12, 20, 2, 1, 0, 1));
      tbl.push_back(mk("ff_end",   C_NONE,        0, 20,  3, 20, 20, 4, 0, 1, 1));
      tbl.push_back(mk("end_stop", C_STOP,        0, 20,  0, 20, 20, 0, 0, 0, 1));
      tbl.push_back(mk("rew_pre",  C_REW,         0, 20,  3, 20, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rew_t1",   C_NONE,        0, 20,  0, 12, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rew_noop", C_REW,         0, 20,  3,  4, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rew_zero", C_NONE,        0, 20,  3,  0, 20, 0, 0, 0, 1));
      tbl.push_back(mk("rew_at0",  C_REW,         0, 20,  1,  0, 20, 0, 0, 0, 1));
      tbl.push_back(mk("loop19",   C_PLAY,        1, 20, 79, 19, 20, 1, 1, 0, 1));
      tbl.push_back(mk("loop0",    C_NONE,        1, 20,  0,  0, 20, 1, 1, 0, 1));
      tbl.push_back(mk("loop1",    C_NONE,        1, 20,  3,  1, 20, 1, 1, 0, 1));
      tbl.push_back(mk("loop_stp", C_STOP,        0, 20,  0,  1, 20, 0, 0, 0, 1));
      tbl.push_back(mk("len0",     C_NONE,        0,  0,  1,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("len0_ply", C_PLAY,        0,  0,  2,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("len0_ff",  C_FF,          0,  0,  1,  0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("len20",    C_NONE,        0, 20,  1,  0, 20, 0, 0, 0, 1));
      tbl.push_back(mk("play5",    C_PLAY,        0, 20, 20,  5, 20, 1, 1, 0, 1));
      tbl.push_back(mk("stop5",    C_STOP,        0, 20,  0,  5, 20, 0, 0, 0, 1));
      tbl.push_back(mk("ff_pre",   C_FF,          0, 20,  3,  5, 20, 2, 1, 0, 1));
      tbl.push_back(mk("ff13",     C_NONE,        0, 20,  0, 13, 20, 2, 1, 0, 1));
      tbl.push_back(mk("ff20",     C_NONE,        0, 20,  3, 20, 20, 4, 0, 1, 1));
      tbl.push_back(mk("rw_pre",   C_REW,         0, 20,  3, 20, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rw12",     C_NONE,        0, 20,  0, 12, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rw4",      C_NONE,        0, 20,  3,  4, 20, 3, 1, 0, 1));
      tbl.push_back(mk("rw0",      C_NONE,        0, 20,  3,  0, 20, 0, 0, 0, 1));
      tbl.push_back(mk("play10",   C_PLAY,        0, 20, 40, 10, 20, 1, 1, 0, 1));
      tbl.push_back(mk("stop10",   C_STOP,        0, 20,  0, 10, 20, 0, 0, 0, 1));
      tbl.push_back(mk("clamp6",   C_NONE,        0,  6,  0,  6,  6, 0, 0, 0, 1));
      tbl.push_back(mk("play_max", C_PLAY,        0,  6,  0,  6,  6, 0, 0, 0, 1));
      tbl.push_back(mk("rew6",     C_REW,         0,  6,  3,  6,  6, 3, 1, 0, 1));
      tbl.push_back(mk("rew_uflw", C_NONE,        0,  9,  0,  0,  6, 0, 0, 0, 1));
      tbl.push_back(mk("reload",   C_NONE,        0, 20,  0,  0, 20, 0, 0, 0, 1));

      repeat (2) @(negedge clk_sys);
      expect_now("reset", 0, 0, 0, 0, 0, 0);
      check_out();
      reset_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Rewind arriving on the tick that ends playback: END first, then REW.
      run_vec(mk("tk_play19", C_PLAY, 0, 20, 79, 19, 20, 1, 1, 0, 1));
      run_vec(mk("tk_end_rew", C_REW, 0, 20,  0, 20, 20, 3, 1, 0, 1));
      run_vec(mk("tk_rew4",   C_NONE, 0, 20, 10,  4, 20, 3, 1, 0, 1));
      // FF arriving on the tick that rewinds to 0: tick's STOP wins.
      run_vec(mk("tk_stop_ff", C_FF,  0, 20,  0,  0, 20, 0, 0, 0, 1));

      // Asynchronous reset in the middle of a fast-forward at pos 13.
      run_vec(mk("ar_play5",  C_PLAY, 0, 20, 20,  5, 20, 1, 1, 0, 1));
      run_vec(mk("ar_ff5",    C_FF,   0, 20,  3,  5, 20, 2, 1, 0, 1));
      run_vec(mk("ar_ff13",   C_NONE, 0, 20,  0, 13, 20, 2, 1, 0, 1));
      #2 reset_n = 1'b0;
      #1;
      expect_now("async_rst", 0, 0, 0, 0, 0, 0);
      check_out();
      @(negedge clk_sys);
      reset_n = 1'b1;
      run_vec(mk("post_rst", C_NONE, 0, 20, 1, 0, 20, 0, 0, 0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
